// File: rtl/ifu_fetch_ctrl_if.sv
// ifu_fetch_ctrl_if: instruction-memory, redirect and decode handshake bundle
interface ifu_fetch_ctrl_if #(parameter int ADDR_W = 11);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              fetch_fault;
  modport master (
    output mem_en, mem_addr, instr, instr_pc, instr_valid, fetch_fault,
    input  mem_rdata, redirect, redirect_pc, instr_ready
  );
  modport slave (
    input  mem_en, mem_addr, instr, instr_pc, instr_valid, fetch_fault,
    output mem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: fetch PC sequencer feeding a 2-entry instruction buffer
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          ADDR_W   = 11
) (
  input  logic               clk,
  input  logic               reset,
  ifu_fetch_ctrl_if.master   bus
);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FAULT = 1'b1;
  logic [31:0] pc_q, pc_d, ipc_q, ipc_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  count_q, count_d;
  logic [0:0]  state_q, state_d;
  logic [31:0] bi_q [2];
  logic [31:0] bi_d [2];
  logic [31:0] bp_q [2];
  logic [31:0] bp_d [2];
  logic [1:0]  occ;
  logic        pop, push, issue, pc_ok, tgt_ok, wr;
  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a - RESET_PC) < (32'd1 << (ADDR_W + 2)));
  endfunction
  // Issue decision, next PC/FSM and buffer push/pop; redirect overrides everything
  always_comb begin
    pc_ok      = legal(pc_q);
    tgt_ok     = legal(bus.redirect_pc);
    pop        = (count_q != 2'd0) && bus.instr_ready;
    occ        = count_q + {1'b0, inflight_q} - {1'b0, pop};
    issue      = reset && (state_q == RUN) && !bus.redirect && pc_ok && !occ[1];
    push       = inflight_q && !bus.redirect;
    wr         = (count_q == 2'd1) ^ pop;
    pc_d       = bus.redirect ? bus.redirect_pc : issue ? pc_q + 32'd4 : pc_q;
    inflight_d = issue;
    ipc_d      = issue ? pc_q : ipc_q;
    state_d    = bus.redirect ? (tgt_ok ? RUN : FAULT) :
                 (state_q == RUN && !pc_ok) ? FAULT : state_q;
    count_d    = bus.redirect ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    bi_d       = bi_q;
    bp_d       = bp_q;
    if (pop) begin
      bi_d[0] = bi_q[1];
      bp_d[0] = bp_q[1];
    end
    if (push) begin
      bi_d[wr] = bus.mem_rdata;
      bp_d[wr] = ipc_q;
    end
  end
  // State registers; reset drops buffer, in-flight read and fault immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      ipc_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      state_q    <= RUN;
      bi_q[0]    <= '0;
      bi_q[1]    <= '0;
      bp_q[0]    <= '0;
      bp_q[1]    <= '0;
    end else begin
      pc_q       <= pc_d;
      ipc_q      <= ipc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      state_q    <= state_d;
      bi_q       <= bi_d;
      bp_q       <= bp_d;
    end
  end
  assign bus.mem_en      = issue;
  assign bus.mem_addr    = pc_q[ADDR_W+1:2] - RESET_PC[ADDR_W+1:2];
  assign bus.instr       = bi_q[0];
  assign bus.instr_pc    = bp_q[0];
  assign bus.instr_valid = (count_q != 2'd0);
  assign bus.fetch_fault = (state_q == FAULT);
endmodule
